// File: rtl/debounce_sync.sv
// debounce_sync: two-flop-style synchroniser plus stability-counter debouncer with a registered level output.
// Define DEBOUNCE_EDGE_EN to build the registered rise/fall pulse outputs; otherwise they are tied to 0.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);
    localparam int              CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   flip;
    assign s    = sync[SYNC_STAGES-1];
    // q follows s only after STABLE_CYCLES consecutive differing samples; any agreement restarts the count
    assign flip = (s != q) && (cnt == LAST);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            q    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_in};
            cnt  <= (s == q || flip) ? '0 : cnt + 1'b1;
            if (flip) q <= s;
        end
    end
`ifdef DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= flip & s;
            fall <= flip & ~s;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed scoreboard bench; expected q/rise/fall per clock edge are queued by the
// stimulus and checked by an independent monitor. Pulse expectations are masked when DEBOUNCE_EDGE_EN is off.
module tb_debounce_sync;
`ifdef DEBOUNCE_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif
    typedef struct {
        int    e;
        logic  qv;
        logic  rv;
        logic  fv;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_in = 1'b1;
    logic q, rise, fall;
    int   edge_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    exp_t cur;

    debounce_sync dut (
        .clk  (clk),
        .rst  (rst),
        .d_in (d_in),
        .q    (q),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %b expected %b", name, edge_n, act[2:0], exp[2:0]);
        end
    endtask

    task automatic push(input int lo, input int hi, input logic qv, input logic rv, input logic fv,
                        input string tag);
        for (int e = lo; e <= hi; e++) sbq.push_back('{e, qv, rv & EDGE, fv & EDGE, tag});
    endtask

    task automatic drain();
        while (sbq.size() > 0) @(negedge clk);
        @(negedge clk);
    endtask

    // clean step: q holds for 9 edges, toggles on the 10th with a one-cycle pulse
    task automatic step(input logic v, input string tag);
        int f;
        @(negedge clk);
        d_in = v;
        f = edge_n + 1;
        push(f, f + 8, ~v, 1'b0, 1'b0, tag);
        push(f + 9, f + 9, v, v, ~v, tag);
        push(f + 10, f + 12, v, 1'b0, 1'b0, tag);
        drain();
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].e <= edge_n) begin
            cur = sbq.pop_front();
            if (cur.e < edge_n) check({cur.tag, "_missed"}, 32'd1, 32'd0);
            else check(cur.tag, {29'd0, q, rise, fall}, {29'd0, cur.qv, cur.rv, cur.fv});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, f, e;
        // test 1: reset held with d_in=1
        #3 check("t1_rst_a", {29'd0, q, rise, fall}, 32'd0);
        #5 check("t1_rst_b", {29'd0, q, rise, fall}, 32'd0);
        #4 rst = 1'b0;
        push(2, 10, 1'b0, 1'b0, 1'b0, "t1_wait");
        push(11, 11, 1'b1, 1'b1, 1'b0, "t1_rise");
        push(12, 14, 1'b1, 1'b0, 1'b0, "t1_hold");
        drain();
        // test 2: clean steps
        step(1'b0, "t2_fall");
        step(1'b1, "t2_rise");
        step(1'b0, "t2_fall2");
        // test 3: 5-cycle glitch, then a clean step that must take the full 10 edges
        @(negedge clk);
        s0 = edge_n;
        d_in = 1'b1;
        push(s0 + 1, s0 + 8, 1'b0, 1'b0, 1'b0, "t3_glitch");
        repeat (5) @(negedge clk);
        d_in = 1'b0;
        repeat (2) @(negedge clk);
        step(1'b1, "t3_after");
        step(1'b0, "t3_back");
        // test 4: bounce every 2 cycles for 8 cycles, then hold 1
        @(negedge clk);
        s0 = edge_n;
        push(s0 + 1, s0 + 17, 1'b0, 1'b0, 1'b0, "t4_bounce");
        push(s0 + 18, s0 + 18, 1'b1, 1'b1, 1'b0, "t4_rise");
        push(s0 + 19, s0 + 21, 1'b1, 1'b0, 1'b0, "t4_hold");
        for (int k = 0; k < 8; k++) begin
            d_in = ((k / 2) % 2) == 0;
            @(negedge clk);
        end
        d_in = 1'b1;
        drain();
        // test 5: async reset mid-count with q=1, d_in returned to 1
        @(negedge clk);
        f = edge_n + 1;
        d_in = 1'b0;
        push(f, f + 6, 1'b1, 1'b0, 1'b0, "t5_pre");
        repeat (7) @(negedge clk);
        check("t5_cnt5", 32'(dut.cnt), 32'd5);
        check("t5_q_pre", {31'd0, q}, 32'd1);
        #2 d_in = 1'b1;
        rst = 1'b1;
        #1 check("t5_async_out", {29'd0, q, rise, fall}, 32'd0);
        check("t5_async_cnt", 32'(dut.cnt), 32'd0);
        @(negedge clk);
        check("t5_in_rst", {29'd0, q, rise, fall}, 32'd0);
        rst = 1'b0;
        e = edge_n;
        push(e + 1, e + 9, 1'b0, 1'b0, 1'b0, "t5_wait");
        push(e + 10, e + 10, 1'b1, 1'b1, 1'b0, "t5_rise");
        push(e + 11, e + 12, 1'b1, 1'b0, 1'b0, "t5_hold");
        drain();
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
